econ_frame_packer: RTL



---
 rtl/econ_pkg.sv | 18 +
 rtl/econ_frame_bank.sv | 54 +++++
 rtl/econ_frame_packer.sv | 102 ++++++++++
 3 files changed

// File: rtl/econ_pkg.sv
// Shared widths and types for the econV0 input-port frame packer and its unpacker.
package econ_pkg;

  localparam int ECON_SAMPLE_W  = 18;
  localparam int ECON_N_SAMPLES = 48;
  localparam int ECON_FRAME_W   = ECON_SAMPLE_W * ECON_N_SAMPLES;
  localparam int ECON_OUT_W     = 54;

  typedef logic [ECON_SAMPLE_W-1:0] sample_t;
  typedef logic [ECON_FRAME_W-1:0]  frame_t;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

endpackage

// File: rtl/econ_frame_bank.sv
// One frame buffer: per-slot write demux, EMPTY/FILLING/FULL tracking, zero-on-drain.
module econ_frame_bank
  import econ_pkg::*;
#(
  parameter int SAMPLE_W  = ECON_SAMPLE_W,
  parameter int N_SAMPLES = ECON_N_SAMPLES,
  parameter int IDX_W     = $clog2(N_SAMPLES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [SAMPLE_W-1:0]           wr_dat,
  input  logic                          commit,
  input  logic                          drain,
  output logic [SAMPLE_W*N_SAMPLES-1:0] dat,
  output logic                          full
);

  bank_state_t state_reg;

  // A commit can coincide with the very first write (frame closed at slot 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= BANK_EMPTY;
    end else begin
      case (state_reg)
        BANK_EMPTY:   if (commit) state_reg <= BANK_FULL;
                      else if (wr_en) state_reg <= BANK_FILLING;
        BANK_FILLING: if (commit) state_reg <= BANK_FULL;
        BANK_FULL:    if (drain) state_reg <= BANK_EMPTY;
        default:      state_reg <= BANK_EMPTY;
      endcase
    end
  end

  assign full = (state_reg == BANK_FULL);

  // Zeroing on drain keeps unused slots of a short frame at zero.
  for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_slot
    logic [SAMPLE_W-1:0] slot_reg;

    always_ff @(posedge clk) begin
      if (reset || drain) begin
        slot_reg <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        slot_reg <= wr_dat;
      end
    end

    assign dat[gi*SAMPLE_W +: SAMPLE_W] = slot_reg;
  end

endmodule

// File: rtl/econ_frame_packer.sv
// Packs N_SAMPLES narrow samples into ping-pong frames for the econV0 input_48_rsc port.
// Define ECON_FRAME_PACKER_LAST_CHECK_EN to let s_last close a frame early (flagged by err_short).
module econ_frame_packer
  import econ_pkg::*;
#(
  parameter int SAMPLE_W  = ECON_SAMPLE_W,
  parameter int N_SAMPLES = ECON_N_SAMPLES,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SAMPLE_W-1:0]           s_dat,
  input  logic                          s_vld,
  output logic                          s_rdy,
  input  logic                          s_last,
  output logic [SAMPLE_W*N_SAMPLES-1:0] m_dat,
  output logic                          m_vld,
  input  logic                          m_rdy,
  output logic [CNT_W-1:0]              frame_count,
  output logic                          err_short
);

  localparam int FRAME_W = SAMPLE_W * N_SAMPLES;
  localparam int IDX_W   = $clog2(N_SAMPLES);

  logic               wr_bank_reg;
  logic               rd_bank_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   frame_count_reg;
  logic               err_short_reg;
  logic [FRAME_W-1:0] bank_dat [2];
  logic [1:0]         bank_full;

  logic accept;
  logic last_slot;
  logic short_close;
  logic commit;
  logic drain;

  assign s_rdy     = ~bank_full[wr_bank_reg] & ~reset;
  assign accept    = s_vld & s_rdy;
  assign last_slot = (idx_reg == IDX_W'(N_SAMPLES - 1));

`ifdef ECON_FRAME_PACKER_LAST_CHECK_EN
  assign short_close = s_last & ~last_slot;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign short_close   = 1'b0;
`endif

  assign commit = accept & (last_slot | short_close);
  assign drain  = m_vld & m_rdy;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    econ_frame_bank #(
      .SAMPLE_W  (SAMPLE_W),
      .N_SAMPLES (N_SAMPLES),
      .IDX_W     (IDX_W)
    ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (accept && (wr_bank_reg == 1'(gi))),
      .wr_idx (idx_reg),
      .wr_dat (s_dat),
      .commit (commit && (wr_bank_reg == 1'(gi))),
      .drain  (drain && (rd_bank_reg == 1'(gi))),
      .dat    (bank_dat[gi]),
      .full   (bank_full[gi])
    );
  end

  assign m_vld       = bank_full[rd_bank_reg];
  assign m_dat       = bank_dat[rd_bank_reg];
  assign frame_count = frame_count_reg;
  assign err_short   = err_short_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_reg     <= 1'b0;
      rd_bank_reg     <= 1'b0;
      idx_reg         <= '0;
      frame_count_reg <= '0;
      err_short_reg   <= 1'b0;
    end else begin
      err_short_reg <= accept & short_close;
      if (accept) begin
        if (commit) begin
          idx_reg     <= '0;
          wr_bank_reg <= ~wr_bank_reg;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
      if (drain) begin
        rd_bank_reg     <= ~rd_bank_reg;
        frame_count_reg <= frame_count_reg + 1'b1;
      end
    end
  end

endmodule
